// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: forwarding select, load-use stall,
// redirect flush, and a multi-cycle M-extension stall FSM. Optional counters: PIPELINE_HAZARD_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              RegWriteE,
  input  logic              LoadE,
  input  logic              MulDivE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulDivBusy
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  PerfCycles,
  output logic [CNT_W-1:0]  PerfStalls,
  output logic [CNT_W-1:0]  PerfFlushes
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Out-of-range configurations disable the multi-cycle stall path entirely.
  localparam bit CFG_OK = (MULDIV_LAT >= 1) && (MULDIV_LAT <= 16) && (CNT_W >= 1);
  localparam bit MULTI_CYCLE = CFG_OK && (MULDIV_LAT > 1);
  localparam int CNT_INIT_I = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;
  localparam logic [3:0] CNT_INIT = 4'(CNT_INIT_I);
  localparam logic [REG_AW-1:0] X0 = '0;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        muldiv_stall;
  logic        load_use;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The first cycle of an M op stalls from IDLE; BUSY then counts down the rest,
  // and its final cycle (cnt==0) lets the op leave Execute.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    muldiv_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (MulDivE && MULTI_CYCLE) begin
          muldiv_stall = 1'b1;
          state_next   = BUSY;
          cnt_next     = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          muldiv_stall = 1'b1;
          cnt_next     = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && (RD_M != X0) && (RD_M == RS1_E))
      fwd_a = 2'b10;
    else if (RegWriteW && (RD_W != X0) && (RD_W == RS1_E))
      fwd_a = 2'b01;
    if (RegWriteM && (RD_M != X0) && (RD_M == RS2_E))
      fwd_b = 2'b10;
    else if (RegWriteW && (RD_W != X0) && (RD_W == RS2_E))
      fwd_b = 2'b01;
  end

  assign load_use = LoadE && RegWriteE && (RD_E != X0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));

  // Only the highest-priority event drives the pipeline controls in a given cycle.
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    MulDivBusy = 1'b0;
    if (rst) begin
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
      MulDivBusy = (state == BUSY);
      if (muldiv_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PerfCycles  <= '0;
      PerfStalls  <= '0;
      PerfFlushes <= '0;
    end else begin
      PerfCycles <= PerfCycles + CNT_W'(1);
      if (StallF)
        PerfStalls <= PerfStalls + CNT_W'(1);
      if (FlushD)
        PerfFlushes <= PerfFlushes + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an op-position reference model. Define PIPELINE_HAZARD_CTRL_PERF_EN to check counters.
module tb_pipeline_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic RegWriteE, LoadE, MulDivE, PCSrcE, RegWriteM, RegWriteW;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic l1_stall_f, l1_stall_d, l1_stall_e, l1_flush_d, l1_flush_e, l1_flush_m, l1_busy;
  logic [1:0] l1_fwd_a, l1_fwd_b;
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  logic [CW-1:0] PerfCycles, PerfStalls, PerfFlushes;
  logic [31:0] l1_cyc, l1_st, l1_fl;
`endif

  pipeline_hazard_ctrl #(.REG_AW(AW), .MULDIV_LAT(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDivBusy(MulDivBusy)
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    , .PerfCycles(PerfCycles), .PerfStalls(PerfStalls), .PerfFlushes(PerfFlushes)
`endif
  );

  pipeline_hazard_ctrl #(.REG_AW(AW), .MULDIV_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .LoadE(LoadE), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(l1_stall_f), .StallD(l1_stall_d), .StallE(l1_stall_e),
    .FlushD(l1_flush_d), .FlushE(l1_flush_e), .FlushM(l1_flush_m),
    .ForwardAE(l1_fwd_a), .ForwardBE(l1_fwd_b), .MulDivBusy(l1_busy)
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    , .PerfCycles(l1_cyc), .PerfStalls(l1_st), .PerfFlushes(l1_fl)
`endif
  );

  wire [6:0] ctrl  = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy};
  wire [6:0] ctrl1 = {l1_stall_f, l1_stall_d, l1_stall_e, l1_flush_d, l1_flush_e, l1_flush_m, l1_busy};

  int checks = 0;
  int errors = 0;
  // Model state: 1-based cycle position of the M op currently in Execute, 0 when none.
  int pos4 = 0;
  int pos1 = 0;
  logic [6:0] exp_ctrl, exp_ctrl1;
  logic [1:0] exp_fa, exp_fb;

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int cur_pos(input int pos, input int lat);
    return (pos == 0 && MulDivE && lat > 1) ? 1 : pos;
  endfunction

  function automatic int next_pos(input int pos, input int lat);
    int p;
    p = cur_pos(pos, lat);
    return (p == 0 || p >= lat) ? 0 : p + 1;
  endfunction

  // An M op of latency L stalls in positions 1..L-1 and is BUSY in positions 2..L.
  function automatic logic [6:0] ctrl_ref(input int pos, input int lat);
    int p;
    bit md, busy, lu;
    p = cur_pos(pos, lat);
    md = (p != 0) && (p < lat);
    busy = (p >= 2);
    lu = LoadE && RegWriteE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    if (!rst) return 7'b0;
    if (md) return {6'b111001, busy};
    if (PCSrcE) return {6'b000110, busy};
    if (lu) return {6'b110010, busy};
    return {6'b000000, busy};
  endfunction

  task automatic quiet_inputs;
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {RegWriteE, LoadE, MulDivE, PCSrcE, RegWriteM, RegWriteW} = '0;
  endtask

  task automatic randomize_inputs(input int md_pct, input int pc_pct);
    RS1_D = AW'($urandom_range(0, 7));
    RS2_D = AW'($urandom_range(0, 7));
    RS1_E = AW'($urandom_range(0, 7));
    RS2_E = AW'($urandom_range(0, 7));
    RD_E  = AW'($urandom_range(0, 7));
    RD_M  = AW'($urandom_range(0, 7));
    RD_W  = AW'($urandom_range(0, 7));
    RegWriteE = 1'($urandom_range(0, 1));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    LoadE   = ($urandom_range(0, 99) < 50);
    MulDivE = ($urandom_range(0, 99) < md_pct);
    PCSrcE  = ($urandom_range(0, 99) < pc_pct);
  endtask

  task automatic settle;
    #1;
    exp_fa    = rst ? fwd_ref(RS1_E) : 2'b00;
    exp_fb    = rst ? fwd_ref(RS2_E) : 2'b00;
    exp_ctrl  = ctrl_ref(pos4, LAT);
    exp_ctrl1 = ctrl_ref(pos1, 1);
  endtask

  task automatic advance;
    @(posedge clk);
    if (rst) begin
      pos4 = next_pos(pos4, LAT);
      pos1 = next_pos(pos1, 1);
    end else begin
      pos4 = 0;
      pos1 = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    quiet_inputs();
    RegWriteM = 1'b1; RD_M = 5; RS1_E = 5; RS2_E = 5;
    LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 7; RS1_D = 7; MulDivE = 1'b1;
    settle();
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL reset_ctrl got %b expected %b", ctrl, 7'b0); end
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0) begin errors++; $display("[TB] FAIL reset_fwd got %b expected 0000", {ForwardAE, ForwardBE}); end
    checks++;
    if (ctrl1 !== 7'b0) begin errors++; $display("[TB] FAIL reset_ctrl_lat1 got %b expected %b", ctrl1, 7'b0); end
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    checks++;
    if ({PerfCycles, PerfStalls, PerfFlushes} !== '0) begin errors++; $display("[TB] FAIL reset_perf got %h expected 0", {PerfCycles, PerfStalls, PerfFlushes}); end
`endif
    advance();
    quiet_inputs();
    rst = 1'b1;
    settle();
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL post_reset_idle got %b expected %b", ctrl, 7'b0); end
    advance();
  endtask

  task automatic test_forwarding;
    quiet_inputs();
    RegWriteM = 1'b1; RD_M = 5; RS1_E = 5; RegWriteW = 1'b1; RD_W = 5;
    settle();
    checks++;
    if (ForwardAE !== 2'b10) begin errors++; $display("[TB] FAIL fwd_mem_priority got %b expected 10", ForwardAE); end
    RegWriteM = 1'b0;
    settle();
    checks++;
    if (ForwardAE !== 2'b01) begin errors++; $display("[TB] FAIL fwd_wb got %b expected 01", ForwardAE); end
    RegWriteM = 1'b1; RD_M = 0; RS1_E = 0; RD_W = 0;
    settle();
    checks++;
    if (ForwardAE !== 2'b00) begin errors++; $display("[TB] FAIL fwd_x0 got %b expected 00", ForwardAE); end
    RD_M = 9; RS2_E = 9;
    settle();
    checks++;
    if (ForwardBE !== 2'b10) begin errors++; $display("[TB] FAIL fwd_b_mem got %b expected 10", ForwardBE); end
    advance();
    for (int i = 0; i < 60; i++) begin
      randomize_inputs(0, 20);
      settle();
      checks++;
      if (ForwardAE !== exp_fa) begin errors++; $display("[TB] FAIL fwd_a_rand got %b expected %b", ForwardAE, exp_fa); end
      checks++;
      if (ForwardBE !== exp_fb) begin errors++; $display("[TB] FAIL fwd_b_rand got %b expected %b", ForwardBE, exp_fb); end
      advance();
    end
  endtask

  task automatic test_load_use;
    quiet_inputs();
    LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 7; RS2_D = 7; RS1_D = 3;
    settle();
    checks++;
    if (ctrl !== 7'b1100100) begin errors++; $display("[TB] FAIL load_use_hit got %b expected %b", ctrl, 7'b1100100); end
    advance();
    quiet_inputs();
    settle();
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL load_use_one_cycle got %b expected %b", ctrl, 7'b0); end
    LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 0; RS2_D = 0; RS1_D = 0;
    settle();
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL load_use_x0 got %b expected %b", ctrl, 7'b0); end
    RegWriteE = 1'b0; RD_E = 4; RS1_D = 4;
    settle();
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL load_no_regwrite got %b expected %b", ctrl, 7'b0); end
    advance();
  endtask

  task automatic test_muldiv;
    logic [5:0] se_pat;
    logic [5:0] busy_pat;
    se_pat = 6'b000111;
    busy_pat = 6'b001110;
    quiet_inputs();
    for (int c = 0; c < 6; c++) begin
      MulDivE = (c < 4);
      settle();
      checks++;
      if (StallE !== se_pat[c]) begin errors++; $display("[TB] FAIL muldiv_stall_e cycle %0d got %b expected %b", c + 1, StallE, se_pat[c]); end
      checks++;
      if (MulDivBusy !== busy_pat[c]) begin errors++; $display("[TB] FAIL muldiv_busy cycle %0d got %b expected %b", c + 1, MulDivBusy, busy_pat[c]); end
      checks++;
      if (ctrl !== exp_ctrl) begin errors++; $display("[TB] FAIL muldiv_ctrl cycle %0d got %b expected %b", c + 1, ctrl, exp_ctrl); end
      checks++;
      if (ctrl1 !== 7'b0) begin errors++; $display("[TB] FAIL muldiv_lat1 cycle %0d got %b expected %b", c + 1, ctrl1, 7'b0); end
      advance();
    end
  endtask

  task automatic test_priority;
    quiet_inputs();
    PCSrcE = 1'b1; LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 7; RS1_D = 7;
    settle();
    checks++;
    if (ctrl !== 7'b0001100) begin errors++; $display("[TB] FAIL redirect_over_load_use got %b expected %b", ctrl, 7'b0001100); end
    advance();
    MulDivE = 1'b1;
    settle();
    checks++;
    if (ctrl !== 7'b1110010) begin errors++; $display("[TB] FAIL muldiv_over_redirect got %b expected %b", ctrl, 7'b1110010); end
    advance();
    for (int c = 1; c < 5; c++) begin
      MulDivE = (c < 4);
      settle();
      checks++;
      if (ctrl !== exp_ctrl) begin errors++; $display("[TB] FAIL priority_seq cycle %0d got %b expected %b", c + 1, ctrl, exp_ctrl); end
      checks++;
      if (ctrl1 !== exp_ctrl1) begin errors++; $display("[TB] FAIL priority_lat1 cycle %0d got %b expected %b", c + 1, ctrl1, exp_ctrl1); end
      advance();
    end
  endtask

  task automatic test_reset_mid_busy;
    int nstall;
    quiet_inputs();
    MulDivE = 1'b1;
    RegWriteM = 1'b1; RD_M = 5; RS1_E = 5;
    settle();
    advance();
    settle();
    checks++;
    if (MulDivBusy !== 1'b1) begin errors++; $display("[TB] FAIL busy_before_reset got %b expected 1", MulDivBusy); end
    #2;
    rst = 1'b0;
    pos4 = 0;
    pos1 = 0;
    #1;
    checks++;
    if (ctrl !== 7'b0) begin errors++; $display("[TB] FAIL async_reset_ctrl got %b expected %b", ctrl, 7'b0); end
    checks++;
    if (ForwardAE !== 2'b00) begin errors++; $display("[TB] FAIL async_reset_fwd got %b expected 00", ForwardAE); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    quiet_inputs();
    nstall = 0;
    for (int c = 0; c < 5; c++) begin
      MulDivE = (c < 4);
      settle();
      if (StallE === 1'b1) nstall++;
      checks++;
      if (ctrl !== exp_ctrl) begin errors++; $display("[TB] FAIL after_reset_ctrl cycle %0d got %b expected %b", c + 1, ctrl, exp_ctrl); end
      advance();
    end
    checks++;
    if (nstall !== 3) begin errors++; $display("[TB] FAIL after_reset_stall_count got %0d expected 3", nstall); end
  endtask

  task automatic test_back_to_back;
    int nstall;
    quiet_inputs();
    nstall = 0;
    for (int c = 0; c < 13; c++) begin
      MulDivE = (c < 12);
      settle();
      if (StallF === 1'b1) nstall++;
      checks++;
      if (ctrl !== exp_ctrl) begin errors++; $display("[TB] FAIL back_to_back cycle %0d got %b expected %b", c + 1, ctrl, exp_ctrl); end
      advance();
    end
    checks++;
    if (nstall !== 9) begin errors++; $display("[TB] FAIL back_to_back_stalls got %0d expected 9", nstall); end
  endtask

  task automatic test_random_mix;
    for (int i = 0; i < 200; i++) begin
      randomize_inputs(20, 15);
      settle();
      checks++;
      if (ctrl !== exp_ctrl) begin errors++; $display("[TB] FAIL rand_ctrl iter %0d got %b expected %b", i, ctrl, exp_ctrl); end
      checks++;
      if (ctrl1 !== exp_ctrl1) begin errors++; $display("[TB] FAIL rand_ctrl_lat1 iter %0d got %b expected %b", i, ctrl1, exp_ctrl1); end
      checks++;
      if ({ForwardAE, ForwardBE} !== {exp_fa, exp_fb}) begin errors++; $display("[TB] FAIL rand_fwd iter %0d got %b expected %b", i, {ForwardAE, ForwardBE}, {exp_fa, exp_fb}); end
      advance();
    end
  endtask

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  task automatic test_perf;
    quiet_inputs();
    rst = 1'b0;
    pos4 = 0;
    pos1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      MulDivE = (c < 4);
      PCSrcE = (c == 6);
      settle();
      advance();
    end
    quiet_inputs();
    settle();
    checks++;
    if (PerfCycles !== 4'd4) begin errors++; $display("[TB] FAIL perf_cycles got %0d expected 4", PerfCycles); end
    checks++;
    if (PerfStalls !== 4'd3) begin errors++; $display("[TB] FAIL perf_stalls got %0d expected 3", PerfStalls); end
    checks++;
    if (PerfFlushes !== 4'd1) begin errors++; $display("[TB] FAIL perf_flushes got %0d expected 1", PerfFlushes); end
  endtask
`endif

  initial begin
    quiet_inputs();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_priority();
    test_reset_mid_busy();
    test_back_to_back();
    test_random_mix();
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MULDIV_LAT, default 4, cycles an M-extension op occupies Execute; legal range 1..16.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports RS1_D, RS2_D  input  REG_AW  Decode-stage source registers.
REQ-007 SHALL have ports RS1_E, RS2_E, RD_E  input  REG_AW  Execute-stage sources and destination.
REQ-008 SHALL have ports RegWriteE, LoadE, MulDivE, PCSrcE  input  1 each  Execute writes reg, is load, is multi-cycle M op, redirect taken.
REQ-009 SHALL have ports RD_M, RD_W  input  REG_AW and RegWriteM, RegWriteW  input  1  Memory/Writeback destinations.
REQ-010 SHALL have ports StallF, StallD, StallE, FlushD, FlushE, FlushM  output  1 each  pipeline-register hold/bubble controls.
REQ-011 SHALL have ports ForwardAE, ForwardBE  output  2  00 register file, 01 ResultW, 10 ALU_ResultM.
REQ-012 SHALL have port MulDivBusy  output  1  high while multi-cycle FSM is BUSY.
REQ-013 SHALL, when the macro in REQ-027 is defined, have ports PerfCycles, PerfStalls, PerfFlushes  output  CNT_W each.

Function
REQ-014 SHALL set ForwardAE = 10 when RegWriteM, RD_M!=0, RD_M==RS1_E; else 01 when RegWriteW, RD_W!=0, RD_W==RS1_E; else 00; ForwardBE identically on RS2_E; combinational, no latency.
REQ-015 SHALL never stall, flush or forward for register x0.
REQ-016 SHALL implement FSM with states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-017 SHALL, in IDLE with MulDivE=1 and MULDIV_LAT>1, assert muldiv stall that cycle and move to BUSY with cnt=MULDIV_LAT-2.
REQ-018 SHALL, in BUSY, assert muldiv stall while cnt!=0 and decrement cnt each cycle; in BUSY with cnt==0 deassert stall, ignore MulDivE, return to IDLE.
REQ-019 SHALL give exactly MULDIV_LAT-1 stall cycles per M op; MULDIV_LAT=1 never leaves IDLE; back-to-back M ops each get full latency.
REQ-020 SHALL, during muldiv stall, drive StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0.
REQ-021 SHALL detect load-use when LoadE, RegWriteE, RD_E!=0 and RD_E equals RS1_D or RS2_D, and drive StallF=StallD=1, FlushE=1.
REQ-022 SHALL, on PCSrcE=1, drive FlushD=FlushE=1 and StallF=StallD=0.
REQ-023 SHALL prioritise simultaneous events: muldiv stall > PCSrcE > load-use; lower-priority event produces no output effect that cycle.
REQ-024 SHALL drive MulDivBusy=1 exactly when state is BUSY.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, cnt=0, all Stall/Flush outputs 0, ForwardAE/BE=00, MulDivBusy=0, perf counters 0, asynchronously, including mid-BUSY.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Configuration
REQ-027 SHALL compile the performance counters only when PIPELINE_HAZARD_CTRL_PERF_EN is defined: PerfCycles +1 every cycle out of reset; PerfStalls +1 each cycle StallF=1; PerfFlushes +1 each cycle FlushD=1; all wrap modulo 2^CNT_W.
REQ-028 SHALL, without PIPELINE_HAZARD_CTRL_PERF_EN, omit the three Perf ports and their registers, all other behaviour unchanged.

Verification
REQ-029 SHALL cover: RegWriteM=1, RD_M=5, RS1_E=5, RegWriteW=1, RD_W=5 -> ForwardAE=10; RD_M=0, RS1_E=0 -> ForwardAE=00.
REQ-030 SHALL cover: LoadE=1, RegWriteE=1, RD_E=7, RS2_D=7 -> one cycle StallF=StallD=FlushE=1; same with RD_E=0 -> no stall.
REQ-031 SHALL cover: MULDIV_LAT=4, MulDivE held 4 cycles -> StallE=1 for 3 cycles, MulDivBusy=1 for cycles 2-4, IDLE in cycle 5; MULDIV_LAT=1 -> no stall.
REQ-032 SHALL cover: PCSrcE=1 with load-use hit same cycle -> FlushD=FlushE=1, StallF=0.
REQ-033 SHALL cover: rst=0 in second BUSY cycle -> all outputs 0 immediately; after release, new MulDivE gets full 3 stall cycles.
REQ-034 SHALL cover, with PIPELINE_HAZARD_CTRL_PERF_EN, CNT_W=4: 20 cycles with one 3-cycle stall and one flush -> PerfCycles=4, PerfStalls=3, PerfFlushes=1.
